// File: rtl/multicycle_cpu_if.sv
// multicycle_cpu_if: data-memory request/response bus between the core (master) and memory (slave)
interface multicycle_cpu_if #(
    parameter int XLEN = 32
);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_ready;
    modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_rdata, dmem_ready);
    modport slave (input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_rdata, dmem_ready);
endinterface

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: multicycle RV32I-subset core; define MULTICYCLE_CPU_BRANCH_EN to add BEQ/BNE/BLT/BGE
module multicycle_cpu #(
    parameter int XLEN       = 32,
    parameter int IMEM_DEPTH = 32,
    parameter int NREGS      = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [IMEM_DEPTH-1:0][31:0] imem_init,
    multicycle_cpu_if.master            dmem,
    output logic [XLEN-1:0]             pc,
    output logic [2:0]                  state,
    output logic                        retire,
    output logic                        halted
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int RW = $clog2(NREGS);
    localparam int SW = $clog2(XLEN);
    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_ST  = 7'b0100011;
`ifdef MULTICYCLE_CPU_BRANCH_EN
    localparam logic [6:0] OPC_BR  = 7'b1100011;
`endif
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;
    state_t          r_state, w_next;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_pc, r_a, r_b, r_imm, r_alu, r_mdr;
    logic [XLEN-1:0] r_regs [NREGS];
    logic [6:0]      w_opc, w_f7;
    logic [2:0]      w_f3;
    logic [RW-1:0]   w_rd, w_rs1, w_rs2;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm, w_b, w_alu, w_wdata;
    logic            w_legal, w_shok, w_mem, w_wr;
`ifdef MULTICYCLE_CPU_BRANCH_EN
    logic [XLEN-1:0] r_tgt, w_imm_b;
    logic            r_taken, w_taken;
`endif
    assign w_opc   = r_ir[6:0];
    assign w_f3    = r_ir[14:12];
    assign w_f7    = r_ir[31:25];
    assign w_rd    = r_ir[7+RW-1:7];
    assign w_rs1   = r_ir[15+RW-1:15];
    assign w_rs2   = r_ir[20+RW-1:20];
    assign w_imm_i = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
    assign w_imm_s = {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
`ifdef MULTICYCLE_CPU_BRANCH_EN
    assign w_imm_b = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_imm   = (w_opc == OPC_ST) ? w_imm_s : (w_opc == OPC_BR) ? w_imm_b : w_imm_i;
    assign w_taken = (w_f3 == 3'b000) ? r_a == r_b :
                     (w_f3 == 3'b001) ? r_a != r_b :
                     (w_f3 == 3'b100) ? $signed(r_a) < $signed(r_b) : $signed(r_a) >= $signed(r_b);
`else
    assign w_imm   = (w_opc == OPC_ST) ? w_imm_s : w_imm_i;
`endif
    // Immediate shifts keep only the shamt field; the bits above it must be zero
    assign w_shok  = (XLEN == 64) ? r_ir[31:26] == 6'd0 : r_ir[31:25] == 7'd0;
    assign w_mem   = w_opc == OPC_LD || w_opc == OPC_ST;
    assign w_wr    = w_opc == OPC_OP || w_opc == OPC_IMM || w_opc == OPC_LD;
    assign w_legal = (w_opc == OPC_OP)  ? (w_f7 == 7'd0 || (w_f7 == 7'b0100000 && w_f3 == 3'b000)) :
                     (w_opc == OPC_IMM) ? ((w_f3 != 3'b001 && w_f3 != 3'b101) || w_shok) :
                     w_mem              ? w_f3 == 3'b010 :
`ifdef MULTICYCLE_CPU_BRANCH_EN
                     (w_opc == OPC_BR)  ? !w_f3[1] :
`endif
                     1'b0;
    assign w_b     = (w_opc == OPC_OP) ? r_b : r_imm;
    assign w_alu   = w_mem              ? r_a + r_imm :
                     (w_f3 == 3'b000)   ? ((w_opc == OPC_OP && w_f7[5]) ? r_a - w_b : r_a + w_b) :
                     (w_f3 == 3'b001)   ? r_a << w_b[SW-1:0] :
                     (w_f3 == 3'b010)   ? {{(XLEN-1){1'b0}}, $signed(r_a) < $signed(w_b)} :
                     (w_f3 == 3'b011)   ? {{(XLEN-1){1'b0}}, r_a < w_b} :
                     (w_f3 == 3'b100)   ? r_a ^ w_b :
                     (w_f3 == 3'b101)   ? r_a >> w_b[SW-1:0] :
                     (w_f3 == 3'b110)   ? r_a | w_b : r_a & w_b;
    assign w_wdata = (w_opc == OPC_LD) ? r_mdr : r_alu;
    assign dmem.dmem_req   = r_state == S_MEM;
    assign dmem.dmem_we    = w_opc == OPC_ST;
    assign dmem.dmem_addr  = r_alu;
    assign dmem.dmem_wdata = r_b;
    assign pc     = r_pc;
    assign state  = r_state;
    assign retire = r_state == S_WB;
    assign halted = r_state == S_HALT;
    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else r_state <= w_next;
    end
    // Next-state: memory ops detour through MEM until ready; illegal instructions park in HALT
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC:   w_next = !w_legal ? S_HALT : w_mem ? S_MEM : S_WB;
            S_MEM:    w_next = dmem.dmem_ready ? S_WB : S_MEM;
            S_WB:     w_next = S_FETCH;
            default:  w_next = S_HALT;
        endcase
    end
    // Datapath: each register loads only in the state that owns it; x0 is never written so it stays 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc  <= '0;
            r_ir  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_imm <= '0;
            r_alu <= '0;
            r_mdr <= '0;
`ifdef MULTICYCLE_CPU_BRANCH_EN
            r_tgt   <= '0;
            r_taken <= 1'b0;
`endif
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            if (r_state == S_FETCH) r_ir <= imem_init[r_pc[AW+1:2]];
            if (r_state == S_DECODE) begin
                r_a   <= r_regs[w_rs1];
                r_b   <= r_regs[w_rs2];
                r_imm <= w_imm;
            end
            if (r_state == S_EXEC) begin
                r_alu <= w_alu;
`ifdef MULTICYCLE_CPU_BRANCH_EN
                r_taken <= w_opc == OPC_BR && w_taken;
                r_tgt   <= r_pc + r_imm;
`endif
            end
            if (r_state == S_MEM && dmem.dmem_ready) r_mdr <= dmem.dmem_rdata;
            if (r_state == S_WB) begin
                if (w_wr && w_rd != '0) r_regs[w_rd] <= w_wdata;
`ifdef MULTICYCLE_CPU_BRANCH_EN
                r_pc <= r_taken ? r_tgt : r_pc + XLEN'(4);
`else
                r_pc <= r_pc + XLEN'(4);
`endif
            end
        end
    end
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: scoreboard bench running directed programs through imem_init against a delayed-ready memory
`timescale 1ns/1ps
module tb_multicycle_cpu;
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [31:0][31:0] imem;
    logic [31:0]       pc;
    logic [2:0]        state;
    logic              retire, halted;
    multicycle_cpu_if #(.XLEN(32)) dmem ();
    multicycle_cpu #(.XLEN(32), .IMEM_DEPTH(32), .NREGS(32)) dut (
        .clk(clk), .reset(reset), .imem_init(imem), .dmem(dmem.master),
        .pc(pc), .state(state), .retire(retire), .halted(halted)
    );
    always #5 clk = ~clk;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; int len; } mem_t;
    typedef struct { logic [31:0] pc; int gap; } ret_t;
    mem_t        mq[$];
    ret_t        rq[$];
    logic [31:0] mem [64];
    int total = 0, bad = 0, cyc = 0, last_ret = 0, m_cyc = 0, d_cnt = 0, wp = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask
    function automatic logic [31:0] opi(input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] opr(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] st(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] ld(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] br(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic int delay_for(input logic [31:0] a);
        return (a == 32'd8) ? 3 : (a >= 32'd64) ? 1000 : 0;
    endfunction
    task automatic place(input logic [31:0] w);
        imem[wp] = w;
        wp++;
    endtask
    task automatic ins(input logic [31:0] w, input int gap);
        ret_t r;
        r.pc = 32'(wp * 4);
        r.gap = gap;
        rq.push_back(r);
        place(w);
    endtask
    task automatic em(input logic we, input logic [31:0] a, input logic [31:0] d, input int len);
        mem_t m;
        m.we = we;
        m.addr = a;
        m.wdata = d;
        m.len = len;
        mq.push_back(m);
    endtask
    task automatic wait_halt(input int lim);
        int n;
        n = 0;
        while (!halted && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (!halted) fail("halt_timeout");
    endtask
    always @(posedge clk) cyc++;
    // Memory model: ready after delay_for(addr) extra cycles of a held request
    always @(negedge clk) begin
        if (dmem.dmem_req) begin
            d_cnt++;
            dmem.dmem_ready = d_cnt > delay_for(dmem.dmem_addr);
            dmem.dmem_rdata = mem[dmem.dmem_addr[7:2]];
            if (dmem.dmem_ready && dmem.dmem_we) mem[dmem.dmem_addr[7:2]] = dmem.dmem_wdata;
        end else begin
            d_cnt = 0;
            dmem.dmem_ready = 1'b0;
            dmem.dmem_rdata = '0;
        end
    end
    // Monitor: checks every held request cycle against the head transaction and every retire pulse
    always @(negedge clk) begin
        #1;
        if (!dmem.dmem_req) m_cyc = 0;
        else if (mq.size() != 0) begin
            m_cyc++;
            chk("mem_we", {31'd0, dmem.dmem_we}, {31'd0, mq[0].we});
            chk("mem_addr", dmem.dmem_addr, mq[0].addr);
            if (mq[0].we) chk("mem_wdata", dmem.dmem_wdata, mq[0].wdata);
            if (dmem.dmem_ready) begin
                chk("mem_len", m_cyc, mq[0].len);
                void'(mq.pop_front());
                m_cyc = 0;
            end
        end else if (dmem.dmem_ready) fail("mem_unexpected");
        if (retire) begin
            if (rq.size() == 0) fail("retire_extra");
            else begin
                chk("retire_pc", pc, rq[0].pc);
                if (rq[0].gap != 0) chk("retire_gap", cyc - last_ret, rq[0].gap);
                last_ret = cyc;
                void'(rq.pop_front());
            end
        end
    end
    initial begin
        logic [31:0] acc;
        dmem.dmem_ready = 1'b0;
        dmem.dmem_rdata = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        imem = '0;
        ins(opi(3'd0, 5'd1, 5'd0, 12'd5), 0);
        ins(opi(3'd0, 5'd2, 5'd0, 12'hFFD), 4);
        ins(opr(7'h00, 3'd0, 5'd3, 5'd1, 5'd2), 4);
        ins(opr(7'h20, 3'd0, 5'd4, 5'd2, 5'd1), 4);
        ins(opr(7'h00, 3'd3, 5'd5, 5'd1, 5'd2), 4);
        ins(opr(7'h00, 3'd2, 5'd6, 5'd1, 5'd2), 4);
        ins(st(5'd3, 5'd0, 12'd0), 5);   em(1'b1, 32'd0, 32'd2, 1);
        ins(st(5'd4, 5'd0, 12'd4), 5);   em(1'b1, 32'd4, 32'hFFFFFFF8, 1);
        ins(st(5'd5, 5'd0, 12'd12), 5);  em(1'b1, 32'd12, 32'd1, 1);
        ins(st(5'd6, 5'd0, 12'd16), 5);  em(1'b1, 32'd16, 32'd0, 1);
        ins(st(5'd1, 5'd0, 12'd8), 8);   em(1'b1, 32'd8, 32'd5, 4);
        ins(ld(5'd7, 5'd0, 12'd8), 8);   em(1'b0, 32'd8, 32'd0, 4);
        ins(st(5'd7, 5'd0, 12'd20), 5);  em(1'b1, 32'd20, 32'd5, 1);
        ins(opi(3'd0, 5'd0, 5'd0, 12'd9), 4);
        ins(opr(7'h00, 3'd0, 5'd8, 5'd0, 5'd0), 4);
        ins(st(5'd8, 5'd0, 12'd24), 5);  em(1'b1, 32'd24, 32'd0, 1);
        ins(opi(3'd4, 5'd9, 5'd1, 12'hFFF), 4);
        ins(opi(3'd1, 5'd10, 5'd1, 12'd3), 4);
        ins(opr(7'h00, 3'd5, 5'd11, 5'd2, 5'd1), 4);
        ins(opr(7'h00, 3'd7, 5'd12, 5'd9, 5'd2), 4);
        ins(st(5'd9, 5'd0, 12'd28), 5);  em(1'b1, 32'd28, 32'hFFFFFFFA, 1);
        ins(st(5'd10, 5'd0, 12'd32), 5); em(1'b1, 32'd32, 32'd40, 1);
        ins(st(5'd11, 5'd0, 12'd36), 5); em(1'b1, 32'd36, 32'h07FFFFFF, 1);
        ins(st(5'd12, 5'd0, 12'd40), 5); em(1'b1, 32'd40, 32'hFFFFFFF8, 1);
        ins(opi(3'd2, 5'd13, 5'd2, 12'd0), 4);
        ins(st(5'd13, 5'd0, 12'd44), 5); em(1'b1, 32'd44, 32'd1, 1);
        ins(opr(7'h00, 3'd6, 5'd14, 5'd1, 5'd2), 4);
        ins(opi(3'd3, 5'd15, 5'd1, 12'hFFF), 4);
        ins(st(5'd14, 5'd0, 12'd48), 5); em(1'b1, 32'd48, 32'hFFFFFFFD, 1);
        ins(st(5'd15, 5'd0, 12'd52), 5); em(1'b1, 32'd52, 32'd1, 1);
        place(32'h0000007F);
        repeat (2) @(negedge clk);
        #2;
        chk("rst_pc", pc, 32'd0);
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_req", {31'd0, dmem.dmem_req}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_halt(1000);
        @(negedge clk);
        #2;
        chk("halt_pc", pc, 32'd120);
        chk("halt_state", {29'd0, state}, 32'd7);
        repeat (10) @(negedge clk);
        #2;
        chk("halt_pc_frozen", pc, 32'd120);
        chk("halt_still", {31'd0, halted}, 32'd1);
        chk("retire_left", rq.size(), 32'd0);
        chk("mem_left", mq.size(), 32'd0);
        reset = 1'b1;
        rq.delete();
        mq.delete();
        imem = '0;
        wp = 0;
        ins(opi(3'd0, 5'd1, 5'd0, 12'd5), 0);
        place(st(5'd1, 5'd0, 12'd64));
        em(1'b1, 32'd64, 32'd5, 1001);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 50 && !dmem.dmem_req; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        #2;
        chk("pre_rst_req", {31'd0, dmem.dmem_req}, 32'd1);
        chk("pre_rst_x1", dut.r_regs[1], 32'd5);
        reset = 1'b1;
        #1;
        chk("midmem_req", {31'd0, dmem.dmem_req}, 32'd0);
        chk("midmem_pc", pc, 32'd0);
        chk("midmem_state", {29'd0, state}, 32'd0);
        chk("midmem_retire", {31'd0, retire}, 32'd0);
        chk("midmem_halted", {31'd0, halted}, 32'd0);
        acc = '0;
        for (int i = 0; i < 32; i++) acc = acc | dut.r_regs[i];
        chk("midmem_regs", acc, 32'd0);
        rq.delete();
        mq.delete();
        imem = '0;
        wp = 0;
        ins(opi(3'd0, 5'd1, 5'd0, 12'd1), 0);
`ifdef MULTICYCLE_CPU_BRANCH_EN
        ins(br(3'b001, 5'd1, 5'd0, 13'd12), 4);
        place(32'h0000007F);
        place(32'h0000007F);
        ins(br(3'b000, 5'd1, 5'd1, 13'h1FF8), 4);
`else
        ins(opi(3'd0, 5'd0, 5'd0, 12'd0), 4);
        ins(opi(3'd0, 5'd0, 5'd0, 12'd0), 4);
        ins(opi(3'd0, 5'd0, 5'd0, 12'd0), 4);
        place(br(3'b000, 5'd1, 5'd1, 13'h1FF8));
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_halt(200);
        repeat (3) @(negedge clk);
        #2;
`ifdef MULTICYCLE_CPU_BRANCH_EN
        chk("branch_halt_pc", pc, 32'd8);
`else
        chk("branch_halt_pc", pc, 32'd16);
`endif
        chk("branch_halted", {31'd0, halted}, 32'd1);
        chk("branch_retire_left", rq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
